// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: operation
// encodings and the control state enumeration.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial datapath slice.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Operands are captured on accept, then
// processed one bit per cycle LSB first through a single full adder.
// Subtraction is a + ~b + 1: b is inverted bitwise and the carry flop
// is preloaded with 1. The result is held until downstream accepts it.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_r;
  logic             mode_r;
  logic             carry;
  logic             c_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt;

  logic             sum_bit;
  logic             cout_bit;

  // Operand registers shift right, so the active bit is always bit 0.
  full_adder u_fa (
    .x    (a_r[0]),
    .y    (b_r[0] ^ mode_r),
    .cin  (carry),
    .sum  (sum_bit),
    .cout (cout_bit)
  );

  // Control FSM plus serial datapath; result bits enter at the MSB and
  // land in place after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      mode_r <= MODE_ADD;
      carry  <= 1'b0;
      c_r    <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            mode_r <= mode;
            carry  <= (mode == MODE_SUB);
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          s_r   <= {sum_bit, s_r[WIDTH-1:1]};
          a_r   <= a_r >> 1;
          b_r   <= b_r >> 1;
          carry <= cout_bit;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // MSB slice: carry is the carry into the MSB, cout_bit the
            // carry out of it. Borrow is the inverted carry for subtract.
            c_r   <= cout_bit ^ (mode_r == MODE_SUB);
            ovf_r <= carry ^ cout_bit;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign s         = s_r;
  assign c         = c_r;
  assign ovf       = ovf_r;

endmodule
